// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Error cause encodings reported on err_cause.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  typedef enum logic [2:0] {
    StFetch,
    StWaitMem,
    StDeliver,
    StWaitNpc,
    StHalted,
    StError
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// 8-bit wait counter for outstanding instruction memory reads.
// expired flags the cycle whose increment brings the count to TIMEOUT_CYCLES,
// so the FSM leaves on the edge that ends the TIMEOUT_CYCLES-th wait cycle.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] Limit = 8'(TIMEOUT_CYCLES);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag the increment that reaches the limit.
  always_comb begin
    expired = en && !clr && (count_d == Limit);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, issues single word reads,
// hands the instruction to decode, then waits for the resolved next PC.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] pc_plus4,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  input  logic        halt,
  output logic        fetch_err,
  output logic [1:0]  err_cause
);

  fetch_state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_err_q, fetch_err_d;
  logic [1:0]      err_cause_q, err_cause_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_expired;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(cnt_expired)
  );

  // Counter runs only while a read is outstanding and unanswered.
  always_comb begin
    cnt_en  = (state_q == StWaitMem) && !imem_rvalid;
    cnt_clr = !cnt_en;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      err_cause_q   <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      err_cause_q   <= err_cause_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // After reset the strobe is still low, so FETCH waits one cycle to issue it.
      StFetch: begin
        if (imem_req_q) state_d = StWaitMem;
      end
      StWaitMem: begin
        if (imem_rvalid)      state_d = StDeliver;
        else if (cnt_expired) state_d = StError;
      end
      StDeliver: begin
        if (instr_valid_q && instr_ready) state_d = StWaitNpc;
      end
      StWaitNpc: begin
        if (halt)                                        state_d = StHalted;
        else if (next_pc_valid && (next_pc[1:0] != 2'b00)) state_d = StError;
        else if (next_pc_valid)                          state_d = StFetch;
      end
      StHalted: begin
        if (!halt) state_d = StWaitNpc;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  // Registered output and datapath next values.
  always_comb begin
    imem_req_d    = (state_d == StFetch);
    instr_valid_d = (state_d == StDeliver);
    fetch_err_d   = (state_d == StError);
    err_cause_d   = err_cause_q;
    instr_d       = instr_q;
    pc_d          = pc_q;

    if ((state_q == StWaitMem) && imem_rvalid) begin
      instr_d = imem_rdata;
    end
    if ((state_q == StWaitNpc) && (state_d == StFetch)) begin
      pc_d = next_pc;
    end
    // Latch only the first cause; ERROR is terminal so it never changes afterwards.
    if ((state_q != StError) && (state_d == StError)) begin
      err_cause_d = (state_q == StWaitMem) ? ERR_TIMEOUT : ERR_MISALIGN;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_err   = fetch_err_q;
  assign err_cause   = err_cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; outputs are sampled 1 ns after each rising edge.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        halt;
  logic        fetch_err;
  logic [1:0]  err_cause;

  int n_asserts = 0;
  int n_fail    = 0;

  instr_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .next_pc_valid(next_pc_valid),
    .halt         (halt),
    .fetch_err    (fetch_err),
    .err_cause    (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_req;
    int n_wait;
    bit done;

    rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    next_pc = '0; next_pc_valid = 1'b0; halt = 1'b0;

    // Reset state
    #2;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_cause", 32'(err_cause), 32'd0);
    check("rst_pc4", pc_plus4, 32'h4);
    tick();
    rst = 1'b1;

    // First fetch: request, memory answers one cycle later, deliver the cycle after
    tick();
    check("f1_req", 32'(imem_req), 32'd1);
    check("f1_addr", imem_addr, 32'h0);
    tick();
    check("f1_req_pulse", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    check("f1_valid", 32'(instr_valid), 32'd1);
    check("f1_instr", instr, 32'h1234_5678);
    check("f1_ipc", instr_pc, 32'h0);
    check("f1_pc4", pc_plus4, 32'h4);

    // Backpressure; a next_pc pulse during DELIVER must be ignored
    imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    next_pc = 32'h0000_0080; next_pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      next_pc_valid = 1'b0;
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", instr, 32'h1234_5678);
      check("bp_ipc", instr_pc, 32'h0);
    end
    instr_ready = 1'b1;
    tick();
    check("xfer_valid_drop", 32'(instr_valid), 32'd0);
    check("deliver_npc_ignored", pc_plus4, 32'h4);
    instr_ready = 1'b0;

    // Branch redirect
    next_pc = 32'h0000_0040; next_pc_valid = 1'b1;
    tick();
    next_pc_valid = 1'b0;
    check("br_req", 32'(imem_req), 32'd1);
    check("br_addr", imem_addr, 32'h40);
    check("br_pc4", pc_plus4, 32'h44);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("br_instr", instr, 32'hDEAD_BEEF);
    check("br_ipc", instr_pc, 32'h40);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Halt wins over a simultaneous next_pc_valid
    halt = 1'b1; next_pc = 32'h0000_0100; next_pc_valid = 1'b1;
    tick();
    next_pc_valid = 1'b0;
    check("halt_pc4", pc_plus4, 32'h44);
    check("halt_req", 32'(imem_req), 32'd0);
    tick();
    check("halt_req2", 32'(imem_req), 32'd0);
    check("halt_valid", 32'(instr_valid), 32'd0);
    halt = 1'b0;
    tick();
    check("unhalt_req", 32'(imem_req), 32'd0);

    // Resume at a wrapping address
    next_pc = 32'hFFFF_FFFC; next_pc_valid = 1'b1;
    tick();
    next_pc_valid = 1'b0;
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    check("wrap_err", 32'(fetch_err), 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    check("wrap_instr", instr, 32'h0000_0013);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Misaligned target
    next_pc = 32'h0000_0042; next_pc_valid = 1'b1;
    tick();
    check("mis_err", 32'(fetch_err), 32'd1);
    check("mis_cause", 32'(err_cause), 32'h2);
    check("mis_pc4", pc_plus4, 32'h0);
    next_pc = 32'h0000_0080;
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      imem_rvalid = i[0];
      tick();
      if (imem_req) n_req++;
    end
    imem_rvalid = 1'b0; next_pc_valid = 1'b0;
    check("mis_no_req", 32'(n_req), 32'd0);
    check("mis_sticky", 32'(err_cause), 32'h2);
    check("mis_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("mis_rst_err", 32'(fetch_err), 32'd0);
    check("mis_rst_cause", 32'(err_cause), 32'd0);
    tick();
    rst = 1'b1;

    // Timeout: memory never answers
    tick();
    check("to_req", 32'(imem_req), 32'd1);
    check("to_addr", imem_addr, 32'h0);
    n_wait = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (fetch_err) done = 1'b1;
      else n_wait++;
    end
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_cause", 32'(err_cause), 32'h1);
    check("to_wait_cycles", 32'(n_wait), 32'd4);
    rst = 1'b0;
    #1;
    check("to_rst_err", 32'(fetch_err), 32'd0);
    check("to_rst_cause", 32'(err_cause), 32'd0);
    check("to_rst_instr", instr, 32'h0);
    tick();
    rst = 1'b1;

    // Reset mid-fetch drops the strobe; a late rvalid afterwards is ignored
    tick();
    check("mid_req", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_req_drop", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055;
    tick();
    rst = 1'b1;
    tick();
    check("late_req", 32'(imem_req), 32'd1);
    check("late_valid", 32'(instr_valid), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    check("late_valid2", 32'(instr_valid), 32'd0);
    tick();
    check("late_valid3", 32'(instr_valid), 32'd0);
    check("late_instr", instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
